vga2tmds_encoder: RTL and testbench

//  Parametrised multi-channel DVI/TMDS 8b/10b encoder, pixel-clock domain.

---
 rtl/vga2tmds_encoder_if.sv | 17 +
 rtl/vga2tmds_encoder.sv | 194 +++++++++++++++++++
 tb/tb_vga2tmds_encoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga2tmds_encoder_if.sv
// Video-side bundle for the TMDS encoder.
// The video generator drives pixel data, blanking and control bits as master.
// It receives the encoded 10-bit lane symbols back on tmds.
interface vga2tmds_encoder_if #(
  parameter int C_depth    = 8,
  parameter int C_channels = 3
);
  logic [C_channels*C_depth-1:0] data;
  logic                          blank;
  logic                          hsync;
  logic                          vsync;
  logic [3:0]                    ctl;
  logic [C_channels*10-1:0]      tmds;

  modport master (output data, blank, hsync, vsync, ctl, input tmds);
  modport slave  (input data, blank, hsync, vsync, ctl, output tmds);
endinterface

// File: rtl/vga2tmds_encoder.sv
// Multi-lane DVI/TMDS 8b/10b encoder in the pixel-clock domain.
// Three register stages: input capture, transition minimisation (q_m),
// then DC balancing with a per-lane running disparity counter.
// Control periods emit the fixed CTL tokens and zero the disparity.
module vga2tmds_encoder #(
  parameter int C_depth    = 8,
  parameter int C_channels = 3
) (
  input  logic         clk_pixel,
  input  logic         reset,
  vga2tmds_encoder_if.slave vid
);

  localparam int W = C_channels * C_depth;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  // Widen a C_depth-bit colour to 8 bits by repeating its bits from the MSB down.
  function automatic logic [7:0] expand(input logic [C_depth-1:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[C_depth-1 - ((7-i) % C_depth)];
    end
    return r;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Transition-minimised word; bit 8 records XOR (1) versus XNOR (0) chaining.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d8);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d8);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d8[0]);
    q        = '0;
    q[0]     = d8[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d8[i]) : (q[i-1] ^ d8[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC-balancing step: returns {next disparity, 10-bit symbol}.
  // diff is ones minus zeros of q_m[7:0], computed as 2*n1 - 8.
  function automatic logic [15:0] enc_step(input logic [8:0] qm, input logic [5:0] cnt_u);
    logic signed [5:0] cnt;
    logic signed [5:0] n1q;
    logic signed [5:0] diff;
    logic signed [5:0] nxt;
    logic        [9:0] sym;
    cnt  = $signed(cnt_u);
    n1q  = $signed({2'b00, ones8(qm[7:0])});
    diff = (n1q <<< 1) - 6'sd8;
    if ((cnt == 6'sd0) || (diff == 6'sd0)) begin
      if (qm[8]) begin
        sym = {2'b01, qm[7:0]};
        nxt = cnt + diff;
      end else begin
        sym = {2'b10, ~qm[7:0]};
        nxt = cnt - diff;
      end
    end else if (((cnt > 6'sd0) && (diff > 6'sd0)) || ((cnt < 6'sd0) && (diff < 6'sd0))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt - diff + (qm[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
    end
    return {nxt, sym};
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK00;
      2'b01:   t = TOK01;
      2'b10:   t = TOK10;
      default: t = TOK11;
    endcase
    return t;
  endfunction

  // Lane 0 carries the syncs, lanes 1/2 the ctl pairs, higher lanes are idle.
  function automatic logic [1:0] lane_ctl(input int k, input logic hs, input logic vs,
                                          input logic [3:0] c);
    logic [1:0] r;
    if (k == 0)      r = {vs, hs};
    else if (k == 1) r = c[1:0];
    else if (k == 2) r = c[3:2];
    else             r = 2'b00;
    return r;
  endfunction

  // ---- stage 0: input capture ----
  logic [W-1:0]                  data_p0_q;
  logic                          blank_p0_q;
  logic [C_channels-1:0][1:0]    ctl_p0_d, ctl_p0_q;

  // ---- stage 1: transition-minimised words ----
  logic [C_channels-1:0][8:0]    qm_p1_d, qm_p1_q;
  logic                          blank_p1_q;
  logic [C_channels-1:0][1:0]    ctl_p1_q;

  // ---- stage 2: output symbols and running disparity ----
  logic [C_channels-1:0][9:0]    tmds_d, tmds_q;
  logic [C_channels-1:0][5:0]    cnt_d, cnt_q;

  // Route each lane's control pair from the sync/ctl inputs.
  always_comb begin
    ctl_p0_d = '0;
    for (int k = 0; k < C_channels; k++) begin
      ctl_p0_d[k] = lane_ctl(k, vid.hsync, vid.vsync, vid.ctl);
    end
  end

  // Stage 0 register; reset parks the pipe in a control period with token 00.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      data_p0_q  <= '0;
      blank_p0_q <= 1'b1;
      ctl_p0_q   <= '0;
    end else begin
      data_p0_q  <= vid.data;
      blank_p0_q <= vid.blank;
      ctl_p0_q   <= ctl_p0_d;
    end
  end

  // Depth expansion and XOR/XNOR chaining per lane.
  always_comb begin
    qm_p1_d = '0;
    for (int k = 0; k < C_channels; k++) begin
      qm_p1_d[k] = tmds_qm(expand(data_p0_q[k*C_depth +: C_depth]));
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      qm_p1_q    <= '0;
      blank_p1_q <= 1'b1;
      ctl_p1_q   <= '0;
    end else begin
      qm_p1_q    <= qm_p1_d;
      blank_p1_q <= blank_p0_q;
      ctl_p1_q   <= ctl_p0_q;
    end
  end

  // Choose CTL token or DC-balanced data symbol; blanking zeroes the disparity.
  always_comb begin
    logic [15:0] st;
    st     = '0;
    tmds_d = '0;
    cnt_d  = '0;
    for (int k = 0; k < C_channels; k++) begin
      if (blank_p1_q) begin
        tmds_d[k] = ctl_token(ctl_p1_q[k]);
        cnt_d[k]  = '0;
      end else begin
        st        = enc_step(qm_p1_q[k], cnt_q[k]);
        tmds_d[k] = st[9:0];
        cnt_d[k]  = st[15:10];
      end
    end
  end

  // Stage 2 register: symbols to the serialisers and per-lane disparity.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      tmds_q <= {C_channels{TOK00}};
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign vid.tmds = tmds_q;

endmodule

// File: tb/tb_vga2tmds_encoder.sv
// Directed and randomised bench for vga2tmds_encoder.
// An 8-bit/3-lane instance is tracked every cycle by a behavioural DVI model;
// a 3-bit/3-lane instance covers depth expansion.
module tb_vga2tmds_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga2tmds_encoder_if #(.C_depth(8), .C_channels(3)) vif8 ();
  vga2tmds_encoder_if #(.C_depth(3), .C_channels(3)) vif3 ();

  vga2tmds_encoder #(.C_depth(8), .C_channels(3)) dut8 (
    .clk_pixel (clk),
    .reset     (rst),
    .vid       (vif8)
  );

  vga2tmds_encoder #(.C_depth(3), .C_channels(3)) dut3 (
    .clk_pixel (clk),
    .reset     (rst),
    .vid       (vif3)
  );

  int errors = 0;
  int checks = 0;

  int         mcnt [3];
  logic [9:0] hsym [3][3];
  int         hcnt [3][3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference DVI encoder following the textbook algorithm on integer counts.
  function automatic logic [9:0] model_enc(input int lane, input logic [7:0] d,
                                           input logic b, input logic [1:0] c);
    int         n1, n1q, n0q;
    logic       use_xnor, qm8;
    logic [7:0] qm;
    logic [9:0] sym;
    if (b) begin
      mcnt[lane] = 0;
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      return sym;
    end
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm8 = !use_xnor;
    n1q = $countones(qm);
    n0q = 8 - n1q;
    if (mcnt[lane] == 0 || n1q == n0q) begin
      sym = {~qm8, qm8, (qm8 ? qm : ~qm)};
      mcnt[lane] += qm8 ? (n1q - n0q) : (n0q - n1q);
    end else if ((mcnt[lane] > 0 && n1q > n0q) || (mcnt[lane] < 0 && n0q > n1q)) begin
      sym = {1'b1, qm8, ~qm};
      mcnt[lane] += 2 * int'(qm8) + n0q - n1q;
    end else begin
      sym = {1'b0, qm8, qm};
      mcnt[lane] += -2 * int'(!qm8) + n1q - n0q;
    end
    return sym;
  endfunction

  // After reset the pipe holds two control-period 00 entries.
  task automatic clear_model();
    for (int l = 0; l < 3; l++) begin
      mcnt[l] = 0;
      for (int a = 0; a < 3; a++) begin
        hsym[a][l] = 10'h354;
        hcnt[a][l] = 0;
      end
    end
  endtask

  // Drive one pixel to both instances, clock it, and compare dut8 with the
  // model's output for the pixel driven two steps earlier.
  task automatic step(input logic [23:0] d, input logic [8:0] d3, input logic b,
                      input logic hs, input logic vs, input logic [3:0] c);
    logic [1:0] sel;
    int         cv;
    vif8.data = d;  vif8.blank = b; vif8.hsync = hs; vif8.vsync = vs; vif8.ctl = c;
    vif3.data = d3; vif3.blank = b; vif3.hsync = hs; vif3.vsync = vs; vif3.ctl = c;
    for (int l = 0; l < 3; l++) begin
      hsym[2][l] = hsym[1][l]; hcnt[2][l] = hcnt[1][l];
      hsym[1][l] = hsym[0][l]; hcnt[1][l] = hcnt[0][l];
      sel = (l == 0) ? {vs, hs} : ((l == 1) ? c[1:0] : c[3:2]);
      hsym[0][l] = model_enc(l, d[l*8 +: 8], b, sel);
      hcnt[0][l] = mcnt[l];
    end
    @(posedge clk); #1;
    for (int l = 0; l < 3; l++) begin
      cv = int'($signed(dut8.cnt_q[l]));
      chk($sformatf("model_sym_lane%0d", l), 32'(vif8.tmds[l*10 +: 10]), 32'(hsym[2][l]));
      chk($sformatf("model_cnt_lane%0d", l), cv, hcnt[2][l]);
      chk($sformatf("cnt_range_lane%0d", l), 32'(cv >= -10 && cv <= 10), 32'd1);
    end
  endtask

  initial begin
    int cv;
    clear_model();
    vif8.data = '0; vif8.blank = 1'b1; vif8.hsync = 1'b0; vif8.vsync = 1'b0; vif8.ctl = '0;
    vif3.data = '0; vif3.blank = 1'b1; vif3.hsync = 1'b0; vif3.vsync = 1'b0; vif3.ctl = '0;

    // Reset held with random inputs: idle token on every lane, zero disparity.
    for (int i = 0; i < 4; i++) begin
      vif8.data = 24'($urandom); vif8.blank = 1'($urandom); vif8.hsync = 1'($urandom);
      vif8.vsync = 1'($urandom); vif8.ctl = 4'($urandom);
      vif3.data = 9'($urandom);  vif3.blank = vif8.blank;  vif3.ctl = vif8.ctl;
      @(posedge clk); #1;
      chk("rst_hold_tmds8", 32'(vif8.tmds), 32'({3{10'h354}}));
      chk("rst_hold_tmds3", 32'(vif3.tmds), 32'({3{10'h354}}));
      chk("rst_hold_cnt0", 32'(dut8.cnt_q), 32'd0);
    end
    rst = 1'b0;
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("rel_c1_lane0", 32'(vif8.tmds[9:0]), 32'h354);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("rel_c2_lane0", 32'(vif8.tmds[9:0]), 32'h354);

    // Control tokens on all three lanes, two cycles late.
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'b1001);
    step(24'h0, 9'h0, 1'b1, 1'b1, 1'b0, 4'b1001);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b1, 4'b1001);
    chk("ctl00_lane0", 32'(vif8.tmds[9:0]),   32'h354);
    chk("ctl_lane1",   32'(vif8.tmds[19:10]), 32'h0AB);
    chk("ctl_lane2",   32'(vif8.tmds[29:20]), 32'h154);
    step(24'h0, 9'h0, 1'b1, 1'b1, 1'b1, 4'b1001);
    chk("ctl01_lane0", 32'(vif8.tmds[9:0]), 32'h0AB);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("ctl10_lane0", 32'(vif8.tmds[9:0]), 32'h154);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("ctl11_lane0", 32'(vif8.tmds[9:0]), 32'h2AB);

    // Three black pixels after blanking, then one blank and black again.
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    step(24'h0, 9'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(24'h0, 9'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(24'h0, 9'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("blk0_sym1", 32'(vif8.tmds[9:0]), 32'h100);
    chk("blk0_cnt1", int'($signed(dut8.cnt_q[0])), -8);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("blk0_sym2", 32'(vif8.tmds[9:0]), 32'h3FF);
    chk("blk0_cnt2", int'($signed(dut8.cnt_q[0])), 2);
    step(24'h0, 9'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("blk0_sym3", 32'(vif8.tmds[9:0]), 32'h100);
    chk("blk0_cnt3", int'($signed(dut8.cnt_q[0])), -6);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("reblank_sym", 32'(vif8.tmds[9:0]), 32'h354);
    chk("reblank_cnt", int'($signed(dut8.cnt_q[0])), 0);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("restart_sym", 32'(vif8.tmds[9:0]), 32'h100);
    chk("restart_cnt", int'($signed(dut8.cnt_q[0])), -8);

    // 3-bit depth: 111 -> 0xFF, 101 -> 0xB6.
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    step(24'hFFFFFF, 9'b111111111, 1'b0, 1'b0, 1'b0, 4'h0);
    step(24'hB6B6B6, 9'b101101101, 1'b0, 1'b0, 1'b0, 4'h0);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("d3_111_sym", 32'(vif3.tmds[9:0]), 32'h200);
    chk("d3_111_cnt", int'($signed(dut3.cnt_q[0])), -8);
    step(24'h0, 9'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("d3_101_sym", 32'(vif3.tmds[9:0]), 32'h2C7);
    chk("d3_101_cnt", int'($signed(dut3.cnt_q[0])), -6);
    chk("d8_B6_sym",  32'(vif8.tmds[9:0]), 32'h2C7);

    // Random pixels with random blanking, with a reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        rst = 1'b1;
        #1;
        chk("midrst_tmds", 32'(vif8.tmds), 32'({3{10'h354}}));
        chk("midrst_cnt",  32'(dut8.cnt_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
      end
      step(24'($urandom), 9'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom),
           1'($urandom), 4'($urandom));
    end
    cv = int'($signed(dut8.cnt_q[0]));
    chk("final_range", 32'(cv >= -10 && cv <= 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
